// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: flop-array backing store with configurable wait states, byte-lane
// writes, a read-only low region and a two-cycle ERROR response.
module ahb_lite_sram_slave #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned MEM_BYTES   = 4096,
   parameter int unsigned WAIT_STATES = 0,
   parameter int unsigned RO_BYTES    = 0
) (
   input  logic                  hclk,
   input  logic                  hreset,
   input  logic                  HSEL,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic                  HWRITE,
   input  logic [1:0]            HTRANS,
   input  logic [2:0]            HSIZE,
   input  logic [2:0]            HBURST,
   input  logic [3:0]            HPROT,
   input  logic [DATA_WIDTH-1:0] HWDATA,
   input  logic                  HREADYMUX,
   input  logic                  HMASTLOCK,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic [DATA_WIDTH-1:0] HRDATA
);

   localparam int unsigned NBYTES = DATA_WIDTH / 8;
   localparam int unsigned OFFS   = $clog2(NBYTES);
   localparam int unsigned MEMW   = $clog2(MEM_BYTES);
   localparam int unsigned WORDS  = MEM_BYTES / NBYTES;
   localparam int unsigned IDXW   = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {StIdle, StWait, StErr1, StErr2} state_e;

   state_e                state_q, state_d;
   logic [2:0]            cnt_q, cnt_d;
   logic [IDXW-1:0]       idx_q, idx_d;
   logic                  write_q, write_d;
   logic [NBYTES-1:0]     mask_q, mask_d;
   logic                  pend_q, pend_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [DATA_WIDTH-1:0] mem [WORDS];

   logic                  capture, size_err, align_err, range_err, ro_err, acc_err;
   logic [OFFS-1:0]       low_addr;
   logic [NBYTES-1:0]     lanes;
   logic [IDXW-1:0]       haddr_idx, rd_idx;
   logic                  rd_load, wr_now;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  unused_ok;

   assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

   assign low_addr  = HADDR[OFFS-1:0];
   assign haddr_idx = HADDR[OFFS +: IDXW];
   assign capture   = HSEL & HREADYMUX & HTRANS[1] & HREADYOUT;
   assign size_err  = 32'(HSIZE) > OFFS;
   assign align_err = (32'(low_addr) & ((32'd1 << HSIZE) - 32'd1)) != 32'd0;

   // MEM_BYTES is a power of two, so any set bit above MEMW means out of range.
   if (ADDR_WIDTH > MEMW) begin : g_range
      assign range_err = |HADDR[ADDR_WIDTH-1:MEMW];
   end else begin : g_no_range
      assign range_err = 1'b0;
   end

   if (RO_BYTES > 0) begin : g_ro
      assign ro_err = HWRITE & (HADDR < ADDR_WIDTH'(RO_BYTES));
   end else begin : g_no_ro
      assign ro_err = 1'b0;
   end

   assign acc_err = size_err | align_err | range_err | ro_err;
   assign wr_now  = pend_q & write_q;

   // A lane is active when it sits in the same size-aligned chunk as the address.
   always_comb begin
      lanes = '0;
      for (int i = 0; i < NBYTES; i++) begin
         lanes[i] = (32'(i) >> HSIZE) == (32'(low_addr) >> HSIZE);
      end
   end

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
         write_q <= 1'b0;
         mask_q  <= '0;
         pend_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         write_q <= write_d;
         mask_q  <= mask_d;
         pend_q  <= pend_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      write_d = write_q;
      mask_d  = mask_q;
      pend_d  = 1'b0;
      rd_load = 1'b0;
      rd_idx  = haddr_idx;
      unique case (state_q)
         StWait: begin
            rd_idx = idx_q;
            if (cnt_q <= 3'd1) begin
               state_d = StIdle;
               pend_d  = 1'b1;
               rd_load = !write_q;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         StErr1: state_d = StErr2;
         StIdle, StErr2: begin
            state_d = StIdle;
            if (capture) begin
               idx_d   = haddr_idx;
               write_d = HWRITE;
               mask_d  = lanes;
               if (acc_err) begin
                  state_d = StErr1;
               end else if (WAIT_STATES == 0) begin
                  pend_d  = 1'b1;
                  rd_load = !HWRITE;
               end else begin
                  state_d = StWait;
                  cnt_d   = 3'(WAIT_STATES);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      HREADYOUT = 1'b1;
      HRESP     = 1'b0;
      unique case (state_q)
         StIdle: ;
         StWait: HREADYOUT = 1'b0;
         StErr1: begin
            HREADYOUT = 1'b0;
            HRESP     = 1'b1;
         end
         StErr2: HRESP = 1'b1;
         default: ;
      endcase
   end

   // Forward a same-edge write into the read so HRDATA always shows post-write data.
   always_comb begin
      rd_word = mem[rd_idx];
      if (wr_now && (idx_q == rd_idx)) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (mask_q[i]) rd_word[8*i +: 8] = HWDATA[8*i +: 8];
         end
      end
      rdata_d = rd_load ? rd_word : '0;
   end

   always_ff @(posedge hclk) begin
      if (wr_now && !hreset) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (mask_q[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
         end
      end
   end

   assign HRDATA = rdata_q;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Bench for ahb_lite_sram_slave: two instances (zero-wait / two-wait with RO region) checked
// against a byte-level memory model, directed vector table and hand-written corner sequences.
module tb_ahb_lite_sram_slave;

   localparam int unsigned MEM = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  hsel, hwrite, hmastlock, hreadyout, hresp, hreadymux, blk;
   logic [31:0] haddr [2];
   logic [31:0] hwdata [2];
   logic [31:0] hrdata [2];
   logic [1:0]  htrans [2];
   logic [2:0]  hsize [2];
   logic [2:0]  hburst [2];
   logic [3:0]  hprot [2];

   int unsigned ws [2] = '{0, 2};
   int unsigned ro [2] = '{0, 256};

   logic [7:0]  rmem [2][MEM];
   bit          rknown [2][MEM];
   int          passed = 0;
   int          total = 0;

   always #5 clk = ~clk;
   assign hreadymux = hreadyout & ~blk;

   ahb_lite_sram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_BYTES(MEM), .WAIT_STATES(0),
                         .RO_BYTES(0)) dut0 (
      .hclk(clk), .hreset(rst), .HSEL(hsel[0]), .HADDR(haddr[0]), .HWRITE(hwrite[0]),
      .HTRANS(htrans[0]), .HSIZE(hsize[0]), .HBURST(hburst[0]), .HPROT(hprot[0]),
      .HWDATA(hwdata[0]), .HREADYMUX(hreadymux[0]), .HMASTLOCK(hmastlock[0]),
      .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0]));

   ahb_lite_sram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_BYTES(MEM), .WAIT_STATES(2),
                         .RO_BYTES(256)) dut1 (
      .hclk(clk), .hreset(rst), .HSEL(hsel[1]), .HADDR(haddr[1]), .HWRITE(hwrite[1]),
      .HTRANS(htrans[1]), .HSIZE(hsize[1]), .HBURST(hburst[1]), .HPROT(hprot[1]),
      .HWDATA(hwdata[1]), .HREADYMUX(hreadymux[1]), .HMASTLOCK(hmastlock[1]),
      .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1]));

   typedef struct {
      int          d;
      bit          wr;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
      bit          err;
      bit          chk;
      logic [31:0] rdata;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else passed++;
   endtask

   function automatic bit exp_err(int d, bit wr, logic [31:0] addr, logic [2:0] size);
      if (size > 3'd2) return 1'b1;
      if ((addr % (32'd1 << size)) != 0) return 1'b1;
      if (addr >= MEM) return 1'b1;
      if (wr && addr < ro[d]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_write(input int d, input logic [31:0] addr, input logic [2:0] size,
                              input logic [31:0] wd);
      for (int k = 0; k < (1 << size); k++) begin
         int unsigned a = addr + k;
         rmem[d][a]   = wd[(a % 4) * 8 +: 8];
         rknown[d][a] = 1'b1;
      end
   endtask

   task automatic exp_word(input int d, input logic [31:0] addr, output logic [31:0] w,
                           output logic [31:0] m);
      w = '0;
      m = '0;
      for (int k = 0; k < 4; k++) begin
         int unsigned a = {addr[31:2], 2'b00} + k;
         if (a < MEM && rknown[d][a]) begin
            w[k*8 +: 8] = rmem[d][a];
            m[k*8 +: 8] = 8'hff;
         end
      end
   endtask

   // Single non-pipelined transfer; records per-cycle HREADYOUT/HRESP of the data phase.
   task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wd, output logic [31:0] rd, output logic [7:0] rdy_seq,
                       output logic [7:0] resp_seq, output bit nz);
      @(posedge clk); #1;
      hsel[d] = 1'b1; htrans[d] = 2'b10; hwrite[d] = wr; haddr[d] = addr; hsize[d] = size;
      @(posedge clk); #1;
      hsel[d] = 1'b0; htrans[d] = 2'b00; hwdata[d] = wd;
      rd = '0; rdy_seq = '0; resp_seq = '0; nz = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         rdy_seq[i]  = hreadyout[d];
         resp_seq[i] = hresp[d];
         if (hreadyout[d]) begin
            rd = hrdata[d];
            break;
         end
         if (hrdata[d] != 0) nz = 1'b1;
         @(posedge clk); #1;
      end
   endtask

   task automatic b2b(input logic [31:0] waddr, input logic [2:0] wsize, input logic [31:0] wd,
                      input logic [31:0] raddr, output logic [31:0] rd, output logic rdy,
                      output logic rsp);
      @(posedge clk); #1;
      hsel[0] = 1'b1; htrans[0] = 2'b10; hwrite[0] = 1'b1; haddr[0] = waddr; hsize[0] = wsize;
      @(posedge clk); #1;
      hwrite[0] = 1'b0; haddr[0] = raddr; hsize[0] = 3'd2; hwdata[0] = wd;
      @(posedge clk); #1;
      hsel[0] = 1'b0; htrans[0] = 2'b00;
      @(negedge clk);
      rd = hrdata[0]; rdy = hreadyout[0]; rsp = hresp[0];
   endtask

   // One address-phase cycle that must not start an access (IDLE/BUSY or HREADYMUX low).
   task automatic no_capture(input int d, input logic [1:0] tr, input bit block,
                             input logic [31:0] addr, input string name);
      @(posedge clk); #1;
      hsel[d] = 1'b1; htrans[d] = tr; hwrite[d] = 1'b1; haddr[d] = addr; hsize[d] = 3'd2;
      blk[d] = block;
      @(posedge clk); #1;
      hsel[d] = 1'b0; htrans[d] = 2'b00; blk[d] = 1'b0; hwdata[d] = 32'h0;
      @(negedge clk);
      check({name, "_rdy"}, 64'(hreadyout[d]), 64'd1);
      check({name, "_resp"}, 64'(hresp[d]), 64'd0);
      check({name, "_rdata"}, 64'(hrdata[d]), 64'd0);
   endtask

   vec_t        tbl[$];
   logic [31:0] rd, w, m, a;
   logic [7:0]  rdy_seq, resp_seq;
   logic [2:0]  sz;
   logic        rdy, rsp;
   bit          nz, wr, e;
   int          n, d;

   initial begin
      rst = 1'b1;
      hsel = '0; hwrite = '0; hmastlock = '0; blk = '0;
      for (int i = 0; i < 2; i++) begin
         haddr[i] = '0; hwdata[i] = '0; htrans[i] = 2'b00; hsize[i] = 3'd2;
         hburst[i] = 3'd0; hprot[i] = 4'h3;
      end
      #1;
      check("reset_rdy", 64'(hreadyout), 64'h3);
      check("reset_resp", 64'(hresp), 64'h0);
      check("reset_rdata0", 64'(hrdata[0]), 64'h0);
      check("reset_rdata1", 64'(hrdata[1]), 64'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      tbl.push_back(vec_t'{0, 1'b1, 32'h10,  3'd2, 32'h11223344, 1'b0, 1'b0, 32'h0});
      tbl.push_back(vec_t'{0, 1'b1, 32'h13,  3'd0, 32'hAA000000, 1'b0, 1'b0, 32'h0});
      tbl.push_back(vec_t'{0, 1'b0, 32'h10,  3'd2, 32'h0,        1'b0, 1'b1, 32'hAA223344});
      tbl.push_back(vec_t'{0, 1'b0, 32'h11,  3'd1, 32'h0,        1'b1, 1'b0, 32'h0});
      tbl.push_back(vec_t'{0, 1'b1, 32'h11,  3'd1, 32'h55555555, 1'b1, 1'b0, 32'h0});
      tbl.push_back(vec_t'{0, 1'b1, 32'h400, 3'd2, 32'h77777777, 1'b1, 1'b0, 32'h0});
      tbl.push_back(vec_t'{0, 1'b0, 32'h400, 3'd2, 32'h0,        1'b1, 1'b0, 32'h0});
      tbl.push_back(vec_t'{0, 1'b0, 32'h10,  3'd2, 32'h0,        1'b0, 1'b1, 32'hAA223344});
      tbl.push_back(vec_t'{0, 1'b1, 32'h12,  3'd1, 32'hBEEF0000, 1'b0, 1'b0, 32'h0});
      tbl.push_back(vec_t'{0, 1'b0, 32'h10,  3'd2, 32'h0,        1'b0, 1'b1, 32'hBEEF3344});
      tbl.push_back(vec_t'{0, 1'b0, 32'h10,  3'd3, 32'h0,        1'b1, 1'b0, 32'h0});
      tbl.push_back(vec_t'{1, 1'b1, 32'h40,  3'd2, 32'h12345678, 1'b1, 1'b0, 32'h0});
      tbl.push_back(vec_t'{1, 1'b0, 32'h40,  3'd2, 32'h0,        1'b0, 1'b0, 32'h0});
      tbl.push_back(vec_t'{1, 1'b1, 32'hFC,  3'd2, 32'h12345678, 1'b1, 1'b0, 32'h0});
      tbl.push_back(vec_t'{1, 1'b1, 32'h100, 3'd2, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0});
      tbl.push_back(vec_t'{1, 1'b0, 32'h100, 3'd2, 32'h0,        1'b0, 1'b1, 32'hCAFEF00D});
      tbl.push_back(vec_t'{1, 1'b0, 32'h20,  3'd2, 32'h0,        1'b0, 1'b0, 32'h0});
      tbl.push_back(vec_t'{1, 1'b1, 32'h3FC, 3'd2, 32'h0BADC0DE, 1'b0, 1'b0, 32'h0});
      tbl.push_back(vec_t'{1, 1'b0, 32'h3FC, 3'd2, 32'h0,        1'b0, 1'b1, 32'h0BADC0DE});
      tbl.push_back(vec_t'{1, 1'b0, 32'h400, 3'd2, 32'h0,        1'b1, 1'b0, 32'h0});

      foreach (tbl[i]) begin
         xfer(tbl[i].d, tbl[i].wr, tbl[i].addr, tbl[i].size, tbl[i].wdata, rd, rdy_seq, resp_seq,
              nz);
         n = tbl[i].err ? 2 : int'(ws[tbl[i].d]) + 1;
         check($sformatf("tbl%0d_rdy_seq", i), 64'(rdy_seq), 64'(1 << (n - 1)));
         check($sformatf("tbl%0d_resp_seq", i), 64'(resp_seq), tbl[i].err ? 64'h3 : 64'h0);
         check($sformatf("tbl%0d_wait_rdata", i), 64'(nz), 64'd0);
         if (tbl[i].chk) check($sformatf("tbl%0d_rdata", i), 64'(rd), 64'(tbl[i].rdata));
         else if (tbl[i].err || tbl[i].wr) check($sformatf("tbl%0d_rdata0", i), 64'(rd), 64'd0);
         if (!tbl[i].err && tbl[i].wr) model_write(tbl[i].d, tbl[i].addr, tbl[i].size,
                                                    tbl[i].wdata);
      end

      // Write then read the same word back-to-back: read must see forwarded data.
      b2b(32'h10, 3'd2, 32'hDEADBEEF, 32'h10, rd, rdy, rsp);
      model_write(0, 32'h10, 3'd2, 32'hDEADBEEF);
      check("fwd_rdata", 64'(rd), 64'hDEADBEEF);
      check("fwd_rdy", 64'(rdy), 64'd1);
      check("fwd_resp", 64'(rsp), 64'd0);

      // HREADYMUX low / IDLE / BUSY must not start accesses.
      no_capture(0, 2'b10, 1'b1, 32'h400, "blk_err");
      no_capture(0, 2'b10, 1'b1, 32'h10, "blk_wr");
      no_capture(1, 2'b00, 1'b0, 32'h400, "idle");
      no_capture(1, 2'b01, 1'b0, 32'h400, "busy");
      xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, rd, rdy_seq, resp_seq, nz);
      check("blk_unchanged", 64'(rd), 64'hDEADBEEF);

      // Reset in the middle of a waited write drops the write.
      xfer(1, 1'b1, 32'h200, 3'd2, 32'h12345678, rd, rdy_seq, resp_seq, nz);
      model_write(1, 32'h200, 3'd2, 32'h12345678);
      @(posedge clk); #1;
      hsel[1] = 1'b1; htrans[1] = 2'b10; hwrite[1] = 1'b1; haddr[1] = 32'h200; hsize[1] = 3'd2;
      @(posedge clk); #1;
      hsel[1] = 1'b0; htrans[1] = 2'b00; hwdata[1] = 32'hFFFFFFFF;
      @(negedge clk);
      check("rst_in_wait", 64'(hreadyout[1]), 64'd0);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_rdy", 64'(hreadyout[1]), 64'd1);
      check("rst_mid_resp", 64'(hresp[1]), 64'd0);
      check("rst_mid_rdata", 64'(hrdata[1]), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      xfer(1, 1'b0, 32'h200, 3'd2, 32'h0, rd, rdy_seq, resp_seq, nz);
      check("rst_old_data", 64'(rd), 64'h12345678);

      // Randomised back-to-back write/read pairs on the zero-wait slave.
      for (int i = 0; i < 30; i++) begin
         sz = 3'($urandom_range(0, 2));
         a  = 32'($urandom_range(0, MEM - 1)) & ~((32'd1 << sz) - 32'd1);
         w  = $urandom;
         b2b(a, sz, w, {a[31:2], 2'b00}, rd, rdy, rsp);
         model_write(0, a, sz, w);
         exp_word(0, a, w, m);
         check($sformatf("rb2b%0d_rdata", i), 64'(rd & m), 64'(w & m));
         check($sformatf("rb2b%0d_resp", i), 64'(rsp), 64'd0);
      end

      // Randomised single transfers on both slaves against the byte model.
      for (int i = 0; i < 300; i++) begin
         d  = int'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         sz = 3'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) a = 32'(MEM + $urandom_range(0, 255));
         else a = 32'($urandom_range(0, MEM - 1));
         if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
         w = $urandom;
         e = exp_err(d, wr, a, sz);
         xfer(d, wr, a, sz, w, rd, rdy_seq, resp_seq, nz);
         n = e ? 2 : int'(ws[d]) + 1;
         check($sformatf("rnd%0d_rdy_seq", i), 64'(rdy_seq), 64'(1 << (n - 1)));
         check($sformatf("rnd%0d_resp_seq", i), 64'(resp_seq), e ? 64'h3 : 64'h0);
         check($sformatf("rnd%0d_wait_rdata", i), 64'(nz), 64'd0);
         if (e || wr) begin
            check($sformatf("rnd%0d_rdata0", i), 64'(rd), 64'd0);
            if (!e) model_write(d, a, sz, w);
         end else begin
            exp_word(d, a, w, m);
            if (m != 0) check($sformatf("rnd%0d_rdata", i), 64'(rd & m), 64'(w & m));
         end
         if (i % 25 == 0) no_capture(d, 2'($urandom_range(0, 1)), 1'b0, 32'h400, "rnd_idle");
      end

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
